alarm_set_controller: RTL
=========================

Name: alarm_set_controller

Overview:
Front-panel sequencer that lets the user edit the alarm time one digit at a time. It turns debounced button levels into single-cycle digit Inc/Dec pulses, with auto-repeat on hold. Its o_Inc/o_Dec bundles drive the twelve i_*_Digit_Inc/Dec inputs of the alarm time block. It also tracks the selected digit and drives a blink strobe for the display driver.

Parameters:
HOLD_CYCLES, 2500000, cycles an Up/Down must be held before auto-repeat starts (0.5 s at 5 MHz)
REPEAT_CYCLES, 500000, cycles between auto-repeat pulses (0.1 s)
TIMEOUT_CYCLES, 50000000, inactivity cycles in edit mode before automatic exit (10 s)
BLINK_CYCLES, 1250000, half-period of o_Blink (2 Hz)

Ports:
i_Clk_5MHz  in  1  system clock; all logic is on the rising edge
i_Reset  in  1  asynchronous, active-low reset (0 = reset)
i_Set_Btn  in  1  debounced level, synchronous to clock; toggles edit mode
i_Left_Btn  in  1  debounced level; move selection toward digit 0
i_Right_Btn  in  1  debounced level; move selection toward digit 5
i_Up_Btn  in  1  debounced level; increment selected digit
i_Down_Btn  in  1  debounced level; decrement selected digit
o_Set_Mode  out  1  high while editing
o_Digit_Sel  out  3  selected digit: 0=Hours 1st, 1=Hours 2nd, 2=Minutes 1st, 3=Minutes 2nd, 4=Seconds 1st, 5=Seconds 2nd
o_Inc  out  6  one-cycle increment pulses; bit i drives the Inc input of digit i
o_Dec  out  6  one-cycle decrement pulses; bit i drives the Dec input of digit i
o_Blink  out  1  blink strobe for the selected digit; 0 outside edit mode

Behaviour:
- Reset (i_Reset=0, asynchronous) forces all outputs and state to 0: state IDLE, o_Set_Mode=0, o_Digit_Sel=0, o_Inc=0, o_Dec=0, o_Blink=0, all counters 0, edge registers 0.
- Edge detection:
  - Each button has a previous-sample register. A rise is current=1 with previous=0.
  - Every output is registered. A pulse caused by a rise sampled at edge N is high for exactly the one cycle following edge N.
- At most one bit of {o_Inc, o_Dec} is high in any cycle. Bits other than o_Digit_Sel are never driven.
- State IDLE:
  - Outputs quiet.
  - Set rise -> EDIT, o_Set_Mode=1, o_Digit_Sel=0, blink and timeout counters cleared, o_Blink=1.
  - All other buttons are ignored.
- State EDIT:
  - Set rise -> IDLE. Set has priority over every other button in the same cycle.
  - Left rise only: o_Digit_Sel decrements, wrapping 0 -> 5.
  - Right rise only: o_Digit_Sel increments, wrapping 5 -> 0.
  - Left and Right rise together: no change.
  - Up rise only: pulse o_Inc[sel], then -> PRESS_WAIT with the hold counter cleared.
  - Down rise only: pulse o_Dec[sel], then -> PRESS_WAIT.
  - Up and Down rise together: no pulse, stay in EDIT.
  - Left/Right together with Up/Down in the same cycle: the selection moves first, and the pulse uses the new selection.
- State PRESS_WAIT (the direction is latched):
  - Latched button released -> EDIT.
  - Hold counter reaches HOLD_CYCLES-1 -> pulse the latched direction on the current selection, go to REPEAT, clear the counter.
  - Left, Right and the opposite direction are ignored.
  - Set rise -> IDLE with no pulse.
- State REPEAT:
  - While the latched button is held, one pulse every REPEAT_CYCLES.
  - Release -> EDIT.
  - Set rise -> IDLE.
  - Other buttons are ignored.
- Timeout counter:
  - Counts in EDIT only.
  - Cleared on any button rise, and held at 0 in PRESS_WAIT and REPEAT.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE.
- o_Blink: toggles every BLINK_CYCLES while o_Set_Mode=1. It restarts high on entry to EDIT and on every selection change.
- Leaving edit mode for any reason:
  - o_Set_Mode=0 and o_Blink=0 on the next cycle.
  - o_Digit_Sel keeps its value until the next entry to EDIT, which resets it to 0.
- Buttons already held at release of reset create no rise until they are released and pressed again.
- Counter widths use $clog2 of the matching parameter. No arithmetic overflow is possible.

Test Plan:
(Bench parameters: HOLD_CYCLES=8, REPEAT_CYCLES=4, TIMEOUT_CYCLES=50, BLINK_CYCLES=3.)
- Set pulse, then Right x3, then Up pulse -> o_Set_Mode=1; o_Digit_Sel 0->1->2->3; o_Inc=6'b001000 for exactly 1 cycle, one cycle after the Up rise.
- In EDIT at sel=0: Left -> sel=5. Then Right -> sel=0. Then Left and Right in the same cycle -> sel stays 0.
- Down held for 20 cycles at sel=4 -> o_Dec=6'b010000 pulses at cycles +1, +9, +13, +17 after the rise. After release, no further pulses.
- Up and Down rise in the same cycle -> no pulse, state EDIT. Set during a held Up in REPEAT -> o_Set_Mode=0 next cycle, no further o_Inc.
- Enter EDIT, then no input -> o_Set_Mode drops 50 cycles after the last rise. o_Blink toggles every 3 cycles before that, then stays 0.
- i_Reset=0 asserted mid-REPEAT (asynchronously, between clock edges) -> all outputs 0 immediately. Up still held when reset releases -> no pulse until Up is released and pressed again.

Source files
------------

// File: rtl/alarm_set_controller.sv
`default_nettype none
// ============================================================================
// Module   : alarm_set_controller
// Purpose  : Front-panel sequencer for editing the alarm time one digit at a
//            time. Converts debounced button levels into single-cycle digit
//            Inc/Dec pulses (with auto-repeat on hold), tracks the selected
//            digit, and drives a blink strobe for the display driver.
// Ports    : i_Clk_5MHz   - system clock, rising edge
//            i_Reset      - asynchronous active-low reset
//            i_Set_Btn    - toggles edit mode
//            i_Left_Btn   - move selection toward digit 0 (wraps 0 -> 5)
//            i_Right_Btn  - move selection toward digit 5 (wraps 5 -> 0)
//            i_Up_Btn     - increment selected digit (auto-repeat on hold)
//            i_Down_Btn   - decrement selected digit (auto-repeat on hold)
//            o_Set_Mode   - high while editing
//            o_Digit_Sel  - selected digit index 0..5
//            o_Inc/o_Dec  - one-hot, one-cycle pulses per digit
//            o_Blink      - blink strobe, 0 outside edit mode
// Revision : 1.0 - initial release
// ============================================================================
module alarm_set_controller #(
    parameter int HOLD_CYCLES    = 2500000,
    parameter int REPEAT_CYCLES  = 500000,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int BLINK_CYCLES   = 1250000
) (
    input  logic       i_Clk_5MHz,
    input  logic       i_Reset,
    input  logic       i_Set_Btn,
    input  logic       i_Left_Btn,
    input  logic       i_Right_Btn,
    input  logic       i_Up_Btn,
    input  logic       i_Down_Btn,
    output logic       o_Set_Mode,
    output logic [2:0] o_Digit_Sel,
    output logic [5:0] o_Inc,
    output logic [5:0] o_Dec,
    output logic       o_Blink
);

    // Counter widths; guarded so a parameter of 1 still yields a 1-bit counter.
    localparam int HOLD_W  = (HOLD_CYCLES    > 1) ? $clog2(HOLD_CYCLES)    : 1;
    localparam int REP_W   = (REPEAT_CYCLES  > 1) ? $clog2(REPEAT_CYCLES)  : 1;
    localparam int TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_CYCLES   > 1) ? $clog2(BLINK_CYCLES)   : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]   REP_LAST   = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EDIT       = 2'd1,
        PRESS_WAIT = 2'd2,
        REPEAT     = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic                 armed;
    logic [4:0]           prev_btn;
    logic                 dir, dir_nxt;          // 1 = Down latched, 0 = Up
    logic [HOLD_W-1:0]    hold_cnt, hold_cnt_nxt;
    logic [REP_W-1:0]     rep_cnt, rep_cnt_nxt;
    logic [TMO_W-1:0]     tmo_cnt, tmo_cnt_nxt;
    logic [BLINK_W-1:0]   blink_cnt, blink_cnt_nxt;

    logic                 set_mode_nxt;
    logic [2:0]           sel_nxt;
    logic [5:0]           inc_nxt;
    logic [5:0]           dec_nxt;
    logic                 blink_nxt;

    logic [4:0]           buttons;
    logic [4:0]           rise;
    logic                 rise_set, rise_left, rise_right, rise_up, rise_down;
    logic                 held;
    logic                 leave;
    logic                 pulse_req;
    logic                 pulse_is_dec;
    logic [2:0]           pulse_sel;
    logic [2:0]           moved_sel;

    assign buttons = {i_Set_Btn, i_Left_Btn, i_Right_Btn, i_Up_Btn, i_Down_Btn};

    // The first clock after reset only loads the previous-sample registers,
    // so a button already held at reset release produces no rise.
    assign rise = armed ? (buttons & ~prev_btn) : 5'b00000;
    assign {rise_set, rise_left, rise_right, rise_up, rise_down} = rise;

    assign held = dir ? i_Down_Btn : i_Up_Btn;

    always_comb begin
        state_nxt     = state;
        dir_nxt       = dir;
        set_mode_nxt  = o_Set_Mode;
        sel_nxt       = o_Digit_Sel;
        inc_nxt       = 6'b000000;
        dec_nxt       = 6'b000000;
        blink_nxt     = 1'b0;
        blink_cnt_nxt = '0;
        hold_cnt_nxt  = '0;
        rep_cnt_nxt   = '0;
        tmo_cnt_nxt   = '0;
        leave         = 1'b0;
        pulse_req     = 1'b0;
        pulse_is_dec  = dir;
        pulse_sel     = o_Digit_Sel;
        moved_sel     = o_Digit_Sel;

        // Free-running blink while in edit mode; entry and selection changes
        // override this below to restart the phase high.
        if (o_Set_Mode) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_nxt = ~o_Blink;
            end else begin
                blink_nxt     = o_Blink;
                blink_cnt_nxt = blink_cnt + 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (rise_set) begin
                    state_nxt     = EDIT;
                    set_mode_nxt  = 1'b1;
                    sel_nxt       = 3'd0;
                    blink_nxt     = 1'b1;
                    blink_cnt_nxt = '0;
                end
            end

            EDIT: begin
                if (rise_set) begin
                    leave = 1'b1;
                end else begin
                    if (rise_left && !rise_right) begin
                        moved_sel = (o_Digit_Sel == 3'd0) ? 3'd5 : o_Digit_Sel - 3'd1;
                    end else if (rise_right && !rise_left) begin
                        moved_sel = (o_Digit_Sel == 3'd5) ? 3'd0 : o_Digit_Sel + 3'd1;
                    end
                    if (moved_sel != o_Digit_Sel) begin
                        sel_nxt       = moved_sel;
                        blink_nxt     = 1'b1;
                        blink_cnt_nxt = '0;
                    end
                    // Exactly one of Up/Down: pulse on the (possibly new) selection.
                    if (rise_up ^ rise_down) begin
                        pulse_req    = 1'b1;
                        pulse_is_dec = rise_down;
                        pulse_sel    = moved_sel;
                        dir_nxt      = rise_down;
                        state_nxt    = PRESS_WAIT;
                    end else if (rise == 5'b00000) begin
                        if (tmo_cnt == TMO_LAST) begin
                            leave = 1'b1;
                        end else begin
                            tmo_cnt_nxt = tmo_cnt + 1'b1;
                        end
                    end
                end
            end

            PRESS_WAIT: begin
                if (rise_set) begin
                    leave = 1'b1;
                end else if (!held) begin
                    state_nxt = EDIT;
                end else if (hold_cnt == HOLD_LAST) begin
                    pulse_req = 1'b1;
                    state_nxt = REPEAT;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end

            REPEAT: begin
                if (rise_set) begin
                    leave = 1'b1;
                end else if (!held) begin
                    state_nxt = EDIT;
                end else if (rep_cnt == REP_LAST) begin
                    pulse_req = 1'b1;
                end else begin
                    rep_cnt_nxt = rep_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (pulse_req) begin
            if (pulse_is_dec) begin
                dec_nxt = 6'd1 << pulse_sel;
            end else begin
                inc_nxt = 6'd1 << pulse_sel;
            end
        end

        // Any exit from edit mode; the selection is deliberately retained.
        if (leave) begin
            state_nxt     = IDLE;
            set_mode_nxt  = 1'b0;
            blink_nxt     = 1'b0;
            blink_cnt_nxt = '0;
            inc_nxt       = 6'b000000;
            dec_nxt       = 6'b000000;
        end
    end

    always_ff @(posedge i_Clk_5MHz or negedge i_Reset) begin
        if (!i_Reset) begin
            state       <= IDLE;
            armed       <= 1'b0;
            prev_btn    <= 5'b00000;
            dir         <= 1'b0;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            tmo_cnt     <= '0;
            blink_cnt   <= '0;
            o_Set_Mode  <= 1'b0;
            o_Digit_Sel <= 3'd0;
            o_Inc       <= 6'b000000;
            o_Dec       <= 6'b000000;
            o_Blink     <= 1'b0;
        end else begin
            state       <= state_nxt;
            armed       <= 1'b1;
            prev_btn    <= buttons;
            dir         <= dir_nxt;
            hold_cnt    <= hold_cnt_nxt;
            rep_cnt     <= rep_cnt_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
            blink_cnt   <= blink_cnt_nxt;
            o_Set_Mode  <= set_mode_nxt;
            o_Digit_Sel <= sel_nxt;
            o_Inc       <= inc_nxt;
            o_Dec       <= dec_nxt;
            o_Blink     <= blink_nxt;
        end
    end

endmodule
`default_nettype wire
